// File: rtl/fnd_pkg.sv
// Shared constants, conversion FSM encoding and double-dabble helpers for the FND drive path.
package fnd_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BIN_W      = 14;
    localparam int unsigned BCD_W      = 16;
    localparam int unsigned MAX_VAL    = 9999;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned NIB_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    // Saturate a binary input to the largest value four BCD digits can show.
    function automatic logic [BIN_W-1:0] clamp_bin(input logic [BIN_W-1:0] v);
        return (v > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : v;
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (r[i*NIB_W +: NIB_W] >= 4'd5) begin
                r[i*NIB_W +: NIB_W] = r[i*NIB_W +: NIB_W] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, start/busy/done handshake.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [BIN_W-1:0]  bin_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o,
    output conv_state_e       state_o,
    output logic [BCD_W-1:0]  bcd_o
);

    conv_state_e              state_q, state_d;
    logic [BIN_W-1:0]         bin_q,   bin_d;
    logic [BCD_W-1:0]         bcd_q,   bcd_d;
    logic [CNT_W-1:0]         cnt_q,   cnt_d;
    logic                     busy_q,  busy_d;
    logic                     done_q,  done_d;
    logic                     ovf_q,   ovf_d;
    logic [BCD_W+BIN_W-1:0]   shifted;

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: accept in IDLE, 14 adjust-and-shift steps, then a single commit cycle.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        shifted = {dd_adjust(bcd_q), bin_q} << 1;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    bin_d   = clamp_bin(bin_i);
                    ovf_d   = (bin_i > BIN_W'(MAX_VAL));
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = shifted;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign ovf_o   = ovf_q;
    assign state_o = state_q;
    assign bcd_o   = bcd_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit FND drive: binary-to-BCD conversion, digit scan, leading-zero blanking.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned SCAN_HZ  = 1000,
    parameter bit          LZB      = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [BIN_W-1:0]  i_value,
    input  logic              i_update,
    input  logic              i_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_ovf,
    output logic [IDX_W-1:0]  o_DigitSelect,
    output logic [NIB_W-1:0]  o_value,
    output logic              o_blank,
    output logic              o_en
);

    localparam int unsigned DIV   = CLK_FREQ / SCAN_HZ;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    conv_state_e         conv_state;
    logic [BCD_W-1:0]    conv_bcd;

    logic [PRE_W-1:0]    pre_q,  pre_d;
    logic [IDX_W-1:0]    idx_q,  idx_d;
    logic [BCD_W-1:0]    disp_q, disp_d;
    logic                en_q;
    logic                scan_tick;
    logic                blank_c;

    bin2bcd_seq u_bin2bcd (
        .clk_i   (i_clk),
        .rst_ni  (i_reset),
        .start_i (i_update),
        .bin_i   (i_value),
        .busy_o  (o_busy),
        .done_o  (o_done),
        .ovf_o   (o_ovf),
        .state_o (conv_state),
        .bcd_o   (conv_bcd)
    );

    // Prescaler wrap, digit advance and display load from the converter's commit cycle.
    always_comb begin
        scan_tick = (pre_q == PRE_W'(DIV - 1));
        pre_d     = scan_tick ? '0 : pre_q + PRE_W'(1);
        idx_d     = scan_tick ? idx_q + IDX_W'(1) : idx_q;
        disp_d    = (conv_state == COMMIT) ? conv_bcd : disp_q;
    end

    // Scan and display registers; the display only changes on commit so no torn value is shown.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            pre_q  <= '0;
            idx_q  <= '0;
            disp_q <= '0;
            en_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            en_q   <= i_en;
        end
    end

    // Digit mux and leading-zero detection for the currently selected index.
    always_comb begin
        o_value = disp_q[NIB_W-1:0];
        blank_c = 1'b0;
        case (idx_q)
            2'd0: o_value = disp_q[3:0];
            2'd1: begin
                o_value = disp_q[7:4];
                blank_c = (disp_q[15:4] == 12'd0);
            end
            2'd2: begin
                o_value = disp_q[11:8];
                blank_c = (disp_q[15:8] == 8'd0);
            end
            2'd3: begin
                o_value = disp_q[15:12];
                blank_c = (disp_q[15:12] == 4'd0);
            end
            default: begin
                o_value = disp_q[3:0];
                blank_c = 1'b0;
            end
        endcase
    end

    assign o_blank       = LZB & blank_c;
    assign o_DigitSelect = idx_q;
    assign o_en          = en_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed self-checking bench for fnd_scan_controller (DIV = 4, leading-zero blanking on).
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [13:0] i_value;
    logic        i_update;
    logic        i_en;
    logic        o_busy;
    logic        o_done;
    logic        o_ovf;
    logic [1:0]  o_DigitSelect;
    logic [3:0]  o_value;
    logic        o_blank;
    logic        o_en;

    int ncmp = 0;
    int nerr = 0;

    logic [3:0] obs_val [4];
    logic       obs_blk [4];

    fnd_scan_controller #(
        .CLK_FREQ (1000),
        .SCAN_HZ  (250),
        .LZB      (1'b1)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_value       (i_value),
        .i_update      (i_update),
        .i_en          (i_en),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_ovf         (o_ovf),
        .o_DigitSelect (o_DigitSelect),
        .o_value       (o_value),
        .o_blank       (o_blank),
        .o_en          (o_en)
    );

    always #5 clk = ~clk;

    // Pulse i_update for one edge; returns at the negedge after the accepting edge.
    task automatic start_conv(input logic [13:0] v);
        @(negedge clk);
        i_value  = v;
        i_update = 1'b1;
        @(negedge clk);
        i_update = 1'b0;
    endtask

    // Count negedges until o_done is seen, capped at 40.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (o_done !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Capture the shown digit and blank flag for every index over 16 cycles.
    task automatic read_digits();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            obs_val[o_DigitSelect] = o_value;
            obs_blk[o_DigitSelect] = o_blank;
        end
    endtask

    task automatic test_reset();
        logic [1:0] exp_idx;
        i_reset = 1'b0; i_update = 1'b0; i_value = '0; i_en = 1'b0;
        repeat (3) @(negedge clk);
        ncmp++;
        if ({o_busy, o_done, o_ovf, o_DigitSelect, o_value, o_blank, o_en} !== 11'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {o_busy, o_done, o_ovf, o_DigitSelect, o_value, o_blank, o_en});
        end
        i_reset = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            exp_idx = 2'((k + 1) / 4);
            ncmp++;
            if (o_DigitSelect !== exp_idx) begin
                nerr++;
                $display("FAIL scan_idx k=%0d: got %0d required %0d", k, o_DigitSelect, exp_idx);
            end
        end
    endtask

    task automatic test_1234();
        logic [3:0] ev [4];
        ev = '{4'd4, 4'd3, 4'd2, 4'd1};
        start_conv(14'd1234);
        for (int i = 0; i < 15; i++) begin
            ncmp++;
            if (o_busy !== 1'b1 || o_done !== 1'b0) begin
                nerr++;
                $display("FAIL busy_1234 cyc%0d: busy=%b done=%b required busy=1 done=0", i, o_busy, o_done);
            end
            @(negedge clk);
        end
        ncmp++;
        if (o_busy !== 1'b0 || o_done !== 1'b1) begin
            nerr++;
            $display("FAIL commit_1234: busy=%b done=%b required busy=0 done=1", o_busy, o_done);
        end
        @(negedge clk);
        ncmp++;
        if (o_done !== 1'b0) begin
            nerr++;
            $display("FAIL done_width_1234: done=%b required 0", o_done);
        end
        read_digits();
        for (int d = 0; d < 4; d++) begin
            ncmp++;
            if (obs_val[d] !== ev[d] || obs_blk[d] !== 1'b0) begin
                nerr++;
                $display("FAIL digit_1234 idx%0d: got %0d blank %b required %0d blank 0", d, obs_val[d], obs_blk[d], ev[d]);
            end
        end
        ncmp++;
        if (o_ovf !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_1234: got %b required 0", o_ovf);
        end
    endtask

    task automatic test_small(input logic [13:0] v, input logic [3:0] d0);
        int c;
        start_conv(v);
        wait_done(c);
        ncmp++;
        if (c !== 15) begin
            nerr++;
            $display("FAIL latency_%0d: got %0d required 15", v, c);
        end
        read_digits();
        ncmp++;
        if (obs_val[0] !== d0 || obs_blk[0] !== 1'b0) begin
            nerr++;
            $display("FAIL digit0_%0d: got %0d blank %b required %0d blank 0", v, obs_val[0], obs_blk[0], d0);
        end
        for (int d = 1; d < 4; d++) begin
            ncmp++;
            if (obs_val[d] !== 4'd0 || obs_blk[d] !== 1'b1) begin
                nerr++;
                $display("FAIL lzb_%0d idx%0d: got %0d blank %b required 0 blank 1", v, d, obs_val[d], obs_blk[d]);
            end
        end
    endtask

    task automatic test_ovf(input logic [13:0] v);
        int c;
        start_conv(v);
        ncmp++;
        if (o_ovf !== 1'b1) begin
            nerr++;
            $display("FAIL ovf_set_%0d: got %b required 1", v, o_ovf);
        end
        wait_done(c);
        ncmp++;
        if (c !== 15) begin
            nerr++;
            $display("FAIL latency_%0d: got %0d required 15", v, c);
        end
        read_digits();
        for (int d = 0; d < 4; d++) begin
            ncmp++;
            if (obs_val[d] !== 4'd9 || obs_blk[d] !== 1'b0) begin
                nerr++;
                $display("FAIL clamp_%0d idx%0d: got %0d blank %b required 9 blank 0", v, d, obs_val[d], obs_blk[d]);
            end
        end
    endtask

    task automatic test_ovf_clear();
        start_conv(14'd5);
        ncmp++;
        if (o_ovf !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_clear: got %b required 0", o_ovf);
        end
        test_small_tail(4'd5);
    endtask

    task automatic test_small_tail(input logic [3:0] d0);
        int c;
        wait_done(c);
        ncmp++;
        if (c !== 15) begin
            nerr++;
            $display("FAIL latency_ovf_clear: got %0d required 15", c);
        end
        read_digits();
        ncmp++;
        if (obs_val[0] !== d0 || obs_blk[1] !== 1'b1) begin
            nerr++;
            $display("FAIL digits_ovf_clear: got %0d blank1 %b required %0d blank1 1", obs_val[0], obs_blk[1], d0);
        end
    endtask

    task automatic test_ignore_busy();
        int c;
        logic [3:0] ev [4];
        logic       eb [4];
        ev = '{4'd1, 4'd2, 4'd3, 4'd0};
        eb = '{1'b0, 1'b0, 1'b0, 1'b1};
        start_conv(14'd321);
        repeat (4) @(negedge clk);
        i_value  = 14'd42;
        i_update = 1'b1;
        @(negedge clk);
        i_update = 1'b0;
        wait_done(c);
        ncmp++;
        if (c !== 10) begin
            nerr++;
            $display("FAIL ignore_latency: got %0d cycles after strobe required 10", c);
        end
        @(negedge clk);
        ncmp++;
        if (o_busy !== 1'b0) begin
            nerr++;
            $display("FAIL ignore_not_queued: busy=%b required 0", o_busy);
        end
        read_digits();
        for (int d = 0; d < 4; d++) begin
            ncmp++;
            if (obs_val[d] !== ev[d] || obs_blk[d] !== eb[d]) begin
                nerr++;
                $display("FAIL ignore_digit idx%0d: got %0d blank %b required %0d blank %b", d, obs_val[d], obs_blk[d], ev[d], eb[d]);
            end
        end
    endtask

    task automatic test_commit_update();
        logic [3:0] ev [4];
        ev = '{4'd8, 4'd8, 4'd0, 4'd0};
        start_conv(14'd88);
        repeat (14) @(negedge clk);
        i_value  = 14'd99;
        i_update = 1'b1;
        @(negedge clk);
        i_update = 1'b0;
        ncmp++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            nerr++;
            $display("FAIL commit_strobe: done=%b busy=%b required done=1 busy=0", o_done, o_busy);
        end
        @(negedge clk);
        ncmp++;
        if (o_busy !== 1'b0) begin
            nerr++;
            $display("FAIL commit_strobe_ignored: busy=%b required 0", o_busy);
        end
        read_digits();
        for (int d = 0; d < 4; d++) begin
            ncmp++;
            if (obs_val[d] !== ev[d]) begin
                nerr++;
                $display("FAIL commit_digit idx%0d: got %0d required %0d", d, obs_val[d], ev[d]);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic seen_done;
        start_conv(14'd1234);
        repeat (7) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        ncmp++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_ovf !== 1'b0) begin
            nerr++;
            $display("FAIL abort_state: busy=%b done=%b ovf=%b required 0 0 0", o_busy, o_done, o_ovf);
        end
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_done === 1'b1 || o_busy === 1'b1) seen_done = 1'b1;
        end
        ncmp++;
        if (seen_done !== 1'b0) begin
            nerr++;
            $display("FAIL abort_no_done: saw done/busy=%b required 0", seen_done);
        end
        read_digits();
        for (int d = 0; d < 4; d++) begin
            ncmp++;
            if (obs_val[d] !== 4'd0 || obs_blk[d] !== (d != 0)) begin
                nerr++;
                $display("FAIL abort_digit idx%0d: got %0d blank %b required 0 blank %b", d, obs_val[d], obs_blk[d], d != 0);
            end
        end
    endtask

    task automatic test_en();
        @(negedge clk);
        i_en = 1'b1;
        #1;
        ncmp++;
        if (o_en !== 1'b0) begin
            nerr++;
            $display("FAIL en_rise_early: got %b required 0", o_en);
        end
        @(negedge clk);
        ncmp++;
        if (o_en !== 1'b1) begin
            nerr++;
            $display("FAIL en_rise: got %b required 1", o_en);
        end
        i_en = 1'b0;
        #1;
        ncmp++;
        if (o_en !== 1'b1) begin
            nerr++;
            $display("FAIL en_fall_early: got %b required 1", o_en);
        end
        @(negedge clk);
        ncmp++;
        if (o_en !== 1'b0) begin
            nerr++;
            $display("FAIL en_fall: got %b required 0", o_en);
        end
    endtask

    initial begin
        test_reset();
        test_1234();
        test_small(14'd7, 4'd7);
        test_small(14'd0, 4'd0);
        test_ovf(14'd12000);
        test_ovf_clear();
        test_ovf(14'd16383);
        test_ignore_busy();
        test_commit_update();
        test_reset_abort();
        test_en();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
